// File: rtl/ifq.sv
// Instruction fetch queue: fetches at a local PC and buffers {inst, pc} pairs in a circular FIFO for dispatch.
// Latency: a cache hit at edge N is visible at the head after edge N (1 cycle); no empty bypass.
// Backpressure: fetch stops while full or redirecting; a pop in the full cycle lets fetch resume the next cycle.
module ifq #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        Icache_rd_en,
    output logic [31:0] Icache_addr,
    input  logic [31:0] Icache_data,
    input  logic        Icache_hit,
    input  logic        Dispatch_ren,
    input  logic        Dispatch_jmp,
    input  logic [31:0] Dispatch_jmp_addr,
    input  logic        Cdb_flush,
    input  logic [31:0] Cdb_flush_addr,
    output logic [31:0] Ifq_inst,
    output logic [31:0] Ifq_pc,
    output logic        Ifq_empty,
    output logic        Ifq_full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [31:0]   r_pc;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_inst [DEPTH];
    logic [31:0]   r_pcq  [DEPTH];

    logic w_redirect;
    logic w_push;
    logic w_pop;

    assign w_redirect   = Dispatch_jmp | Cdb_flush;
    assign Ifq_empty    = (r_count == '0);
    assign Ifq_full     = (r_count == CW'(DEPTH));
    // The reset input gates the request so nothing is fetched while reset is held.
    assign Icache_rd_en = reset & ~Ifq_full & ~w_redirect;
    assign Icache_addr  = r_pc;
    assign w_push       = Icache_rd_en & Icache_hit;
    assign w_pop        = Dispatch_ren & ~Ifq_empty & ~w_redirect;
    assign Ifq_inst     = r_inst[r_head];
    assign Ifq_pc       = r_pcq[r_head];

    // PC, pointers and occupancy; a redirect flushes everything and wins over push/pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc    <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_redirect) begin
            r_pc    <= Cdb_flush ? Cdb_flush_addr : Dispatch_jmp_addr;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
                r_pc   <= r_pc + 32'd4;
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads zero until the first fill.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_inst[i] <= '0;
                r_pcq[i]  <= '0;
            end
        end else if (w_push) begin
            r_inst[r_tail] <= Icache_data;
            r_pcq[r_tail]  <= r_pc;
        end
    end

endmodule

// File: tb/tb_ifq.sv
module tb_ifq;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hDEAD_BEEF;

    logic        clock;
    logic        reset;
    logic        Icache_rd_en;
    logic [31:0] Icache_addr;
    logic [31:0] Icache_data;
    logic        Icache_hit;
    logic        Dispatch_ren;
    logic        Dispatch_jmp;
    logic [31:0] Dispatch_jmp_addr;
    logic        Cdb_flush;
    logic [31:0] Cdb_flush_addr;
    logic [31:0] Ifq_inst;
    logic [31:0] Ifq_pc;
    logic        Ifq_empty;
    logic        Ifq_full;

    int n_cmp = 0;
    int n_err = 0;

    // model state: scoreboard of {inst, pc} and the expected fetch PC
    logic [63:0] sb [$];
    logic [31:0] m_pc;

    ifq #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock(clock),
        .reset(reset),
        .Icache_rd_en(Icache_rd_en),
        .Icache_addr(Icache_addr),
        .Icache_data(Icache_data),
        .Icache_hit(Icache_hit),
        .Dispatch_ren(Dispatch_ren),
        .Dispatch_jmp(Dispatch_jmp),
        .Dispatch_jmp_addr(Dispatch_jmp_addr),
        .Cdb_flush(Cdb_flush),
        .Cdb_flush_addr(Cdb_flush_addr),
        .Ifq_inst(Ifq_inst),
        .Ifq_pc(Ifq_pc),
        .Ifq_empty(Ifq_empty),
        .Ifq_full(Ifq_full)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // one cycle: drive inputs, check outputs against the model, clock, update the model
    task automatic step(input logic hit, input logic ren, input logic jmp, input logic [31:0] ja,
                        input logic fl, input logic [31:0] fa);
        logic redir;
        logic exp_rd;
        redir  = jmp | fl;
        exp_rd = (sb.size() < DEPTH) && !redir;
        Icache_hit        = hit;
        Dispatch_ren      = ren;
        Dispatch_jmp      = jmp;
        Dispatch_jmp_addr = ja;
        Cdb_flush         = fl;
        Cdb_flush_addr    = fa;
        Icache_data       = m_pc ^ KEY;
        #1;
        check_val("rd_en", {31'd0, Icache_rd_en}, {31'd0, exp_rd});
        check_val("addr", Icache_addr, m_pc);
        check_val("empty", {31'd0, Ifq_empty}, {31'd0, sb.size() == 0});
        check_val("full", {31'd0, Ifq_full}, {31'd0, sb.size() == DEPTH});
        if (sb.size() != 0) begin
            check_val("head_pc", Ifq_pc, sb[0][31:0]);
            check_val("head_inst", Ifq_inst, sb[0][63:32]);
        end
        if (redir) begin
            sb.delete();
            m_pc = fl ? fa : ja;
        end else begin
            if (ren && sb.size() != 0) void'(sb.pop_front());
            if (exp_rd && hit) begin
                sb.push_back({m_pc ^ KEY, m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clock);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rd_en"}, {31'd0, Icache_rd_en}, 32'd0);
        check_val({tag, "_addr"}, Icache_addr, RESET_PC);
        check_val({tag, "_empty"}, {31'd0, Ifq_empty}, 32'd1);
        check_val({tag, "_full"}, {31'd0, Ifq_full}, 32'd0);
        check_val({tag, "_inst"}, Ifq_inst, 32'd0);
        check_val({tag, "_pc"}, Ifq_pc, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        Icache_hit = 1'b0; Dispatch_ren = 1'b0; Dispatch_jmp = 1'b0; Cdb_flush = 1'b0;
        Icache_data = '0; Dispatch_jmp_addr = '0; Cdb_flush_addr = '0;
        m_pc = RESET_PC;
        #12;
        check_reset_outputs("rst");
        #6 reset = 1'b1;   // t=18, away from edges

        // fill with always-hit, no pops, then hold while full
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0);
        check_val("fill_hold_pc", m_pc, 32'h10);
        // drain with misses, plus extra pops while empty
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, 0);

        // steady stream: hit and pop every cycle
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0, 0);

        // miss stall at 0x8: jump to 0, two hits, three misses, then hit
        step(0, 0, 1, 32'h0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);

        // redirect collision at count 3: CDB target wins
        step(0, 1, 1, 32'h40, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 32'h100, 1, 32'h200);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);

        // random traffic well past 2*DEPTH pushes and pops, with occasional redirects
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 19) == 0)
                step(1, 1, 1, 32'h300 + 32'(i * 16), 0, 0);
            else
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0, 0);
        end

        // reset mid-operation with count 3 and a miss pending
        step(0, 0, 1, 32'h500, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        check_val("pre_rst_count", 32'(sb.size()), 32'd3);
        Icache_hit = 1'b0;
        Dispatch_ren = 1'b0;
        #1 reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        m_pc = RESET_PC;
        @(negedge clock);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) step(1, i > 1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
